// File: rtl/fpu_seq_ctrl.sv
// Sequencing controller for the shared single-cycle FPU datapath.
// It runs each command through the FPU once, or twice for the R4 fused ops (multiply, then add/sub).
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALUOPS_SIZE
`define ALUOPS_SIZE 4
`define F_ALU_OP_ADD 4'd0
`define F_ALU_OP_SUB 4'd1
`define F_ALU_OP_MUL 4'd2
`define F_ALU_OP_MIN 4'd3
`define F_ALU_OP_MAX 4'd4
`define F_ALU_OP_EQ  4'd5
`define F_ALU_OP_LT  4'd6
`define F_ALU_OP_LE  4'd7
`endif

module fpu_seq_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [3:0]              req_cmd,
  input  logic [`XLEN-1:0]        req_rs1,
  input  logic [`XLEN-1:0]        req_rs2,
  input  logic [`XLEN-1:0]        req_rs3,
  input  logic [4:0]              req_rd,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [`XLEN-1:0]        resp_data,
  output logic [4:0]              resp_rd,
  output logic                    resp_illegal,
  input  logic                    flush,
  output logic                    busy,
  output logic [CNT_W-1:0]        op_count,
  output logic [`XLEN-1:0]        fpu_a,
  output logic [`XLEN-1:0]        fpu_b,
  output logic [`ALUOPS_SIZE-1:0] fpu_op,
  input  logic [`XLEN-1:0]        fpu_result
);

  typedef enum logic [1:0] {S_IDLE, S_PASS1, S_PASS2, S_RESP} state_e;

  typedef struct packed {
    logic [3:0]       cmd;
    logic [`XLEN-1:0] rs3;
    logic [4:0]       rd;
  } cmd_t;

  state_e                  state_q, state_d;
  cmd_t                    cmd_q, cmd_d;
  logic [`XLEN-1:0]        fpu_a_q, fpu_a_d, fpu_b_q, fpu_b_d;
  logic [`ALUOPS_SIZE-1:0] fpu_op_q, fpu_op_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    resp_illegal_q, resp_illegal_d;
  logic [`XLEN-1:0]        resp_data_q, resp_data_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    is_fused, is_illegal;

  function automatic logic [`ALUOPS_SIZE-1:0] op_map(input logic [3:0] c);
    case (c)
      4'd0:    op_map = `F_ALU_OP_ADD;
      4'd1:    op_map = `F_ALU_OP_SUB;
      4'd2:    op_map = `F_ALU_OP_MUL;
      4'd3:    op_map = `F_ALU_OP_MIN;
      4'd4:    op_map = `F_ALU_OP_MAX;
      4'd5:    op_map = `F_ALU_OP_EQ;
      4'd6:    op_map = `F_ALU_OP_LT;
      4'd7:    op_map = `F_ALU_OP_LE;
      default: op_map = `F_ALU_OP_MUL;
    endcase
  endfunction

  assign is_fused   = (cmd_q.cmd[3:2] == 2'b10);
  assign is_illegal = (cmd_q.cmd[3:2] == 2'b11);

  always_comb begin
    state_d        = state_q;
    cmd_d          = cmd_q;
    fpu_a_d        = fpu_a_q;
    fpu_b_d        = fpu_b_q;
    fpu_op_d       = fpu_op_q;
    resp_valid_d   = resp_valid_q;
    resp_illegal_d = resp_illegal_q;
    resp_data_d    = resp_data_q;
    cnt_d          = cnt_q;
    if (flush) begin
      state_d        = S_IDLE;
      resp_valid_d   = 1'b0;
      resp_illegal_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          cmd_d    = '{cmd: req_cmd, rs3: req_rs3, rd: req_rd};
          fpu_a_d  = req_rs1;
          fpu_b_d  = req_rs2;
          fpu_op_d = op_map(req_cmd);
          state_d  = S_PASS1;
        end
        S_PASS1: begin
          if (is_illegal) begin
            resp_data_d    = '0;
            resp_illegal_d = 1'b1;
            resp_valid_d   = 1'b1;
            state_d        = S_RESP;
          end else if (is_fused) begin
            // NMSUB/NMADD negate the product; MSUB/NMADD subtract rs3.
            fpu_a_d  = {fpu_result[`XLEN-1] ^ cmd_q.cmd[1], fpu_result[`XLEN-2:0]};
            fpu_b_d  = cmd_q.rs3;
            fpu_op_d = cmd_q.cmd[0] ? `F_ALU_OP_SUB : `F_ALU_OP_ADD;
            state_d  = S_PASS2;
          end else begin
            resp_data_d  = fpu_result;
            resp_valid_d = 1'b1;
            state_d      = S_RESP;
          end
        end
        S_PASS2: begin
          resp_data_d  = fpu_result;
          resp_valid_d = 1'b1;
          state_d      = S_RESP;
        end
        S_RESP: if (resp_ready) begin
          resp_valid_d   = 1'b0;
          resp_illegal_d = 1'b0;
          cnt_d          = cnt_q + 1'b1;
          state_d        = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      cmd_q          <= '0;
      fpu_a_q        <= '0;
      fpu_b_q        <= '0;
      fpu_op_q       <= `F_ALU_OP_ADD;
      resp_valid_q   <= 1'b0;
      resp_illegal_q <= 1'b0;
      resp_data_q    <= '0;
      cnt_q          <= '0;
    end else begin
      state_q        <= state_d;
      cmd_q          <= cmd_d;
      fpu_a_q        <= fpu_a_d;
      fpu_b_q        <= fpu_b_d;
      fpu_op_q       <= fpu_op_d;
      resp_valid_q   <= resp_valid_d;
      resp_illegal_q <= resp_illegal_d;
      resp_data_q    <= resp_data_d;
      cnt_q          <= cnt_d;
    end
  end

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign resp_rd      = cmd_q.rd;
  assign resp_illegal = resp_illegal_q;
  assign op_count     = cnt_q;
  assign fpu_a        = fpu_a_q;
  assign fpu_b        = fpu_b_q;
  assign fpu_op       = fpu_op_q;

endmodule

// File: tb/tb_fpu_seq_ctrl.sv
// Bench for fpu_seq_ctrl: real-valued FPU stand-in, transaction-level reference model, per-cycle compare.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef ALUOPS_SIZE
`define ALUOPS_SIZE 4
`define F_ALU_OP_ADD 4'd0
`define F_ALU_OP_SUB 4'd1
`define F_ALU_OP_MUL 4'd2
`define F_ALU_OP_MIN 4'd3
`define F_ALU_OP_MAX 4'd4
`define F_ALU_OP_EQ  4'd5
`define F_ALU_OP_LT  4'd6
`define F_ALU_OP_LE  4'd7
`endif
`timescale 1ns/1ps

module tb_fpu_seq_ctrl;
  localparam int CNT_W = 4;

  logic clk = 1'b0, rst_n = 1'b0;
  logic req_valid = 1'b0, resp_ready = 1'b0, flush = 1'b0;
  logic [3:0] req_cmd = '0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0, req_rs3 = '0;
  logic [4:0] req_rd = '0;
  logic req_ready, resp_valid, resp_illegal, busy;
  logic [31:0] resp_data, fpu_a, fpu_b, fpu_result;
  logic [4:0] resp_rd;
  logic [CNT_W-1:0] op_count;
  logic [`ALUOPS_SIZE-1:0] fpu_op;

  always #5 clk = ~clk;

  fpu_seq_ctrl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rs3(req_rs3),
    .req_rd(req_rd), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_rd(resp_rd), .resp_illegal(resp_illegal),
    .flush(flush), .busy(busy), .op_count(op_count), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_op(fpu_op), .fpu_result(fpu_result));

  int total = 0, bad = 0;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Single-precision <-> real for normal numbers and zero.
  function automatic real f2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:23] == 8'd0) return 0.0;
    d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2f(input real r);
    logic [63:0] d;
    int e;
    logic [30:0] v;
    logic [28:0] rem;
    d = $realtobits(r);
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    e = int'(d[62:52]) - 896;
    if (e <= 0) return {d[63], 31'd0};
    if (e >= 255) return {d[63], 8'hFF, 23'd0};
    v = {e[7:0], d[51:29]};
    rem = d[28:0];
    if (rem > 29'h1000_0000 || (rem == 29'h1000_0000 && v[0])) v = v + 31'd1;
    return {d[63], v};
  endfunction

  function automatic logic [31:0] fpu_ref(input logic [31:0] a, input logic [31:0] b,
                                          input logic [`ALUOPS_SIZE-1:0] op);
    real x, y;
    x = f2r(a);
    y = f2r(b);
    case (op)
      `F_ALU_OP_ADD: return r2f(x + y);
      `F_ALU_OP_SUB: return r2f(x - y);
      `F_ALU_OP_MUL: return r2f(x * y);
      `F_ALU_OP_MIN: return (x < y) ? a : b;
      `F_ALU_OP_MAX: return (x > y) ? a : b;
      `F_ALU_OP_EQ:  return {31'd0, x == y};
      `F_ALU_OP_LT:  return {31'd0, x < y};
      `F_ALU_OP_LE:  return {31'd0, x <= y};
      default:       return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb fpu_result = fpu_ref(fpu_a, fpu_b, fpu_op);

  // Reference model: passes left before the response, pending response, completion count.
  int cd = 0;
  bit pend = 1'b0, m_fused = 1'b0, m_ill = 1'b0;
  logic [31:0] m_a = '0, m_b = '0, m_a2 = '0, m_b2 = '0, m_res = '0;
  logic [`ALUOPS_SIZE-1:0] m_op1 = '0, m_op2 = '0;
  logic [4:0] m_rd = '0;
  logic [CNT_W-1:0] m_cnt = '0;
  logic [31:0] t_prod, t_a2;
  logic [`ALUOPS_SIZE-1:0] t_op1, t_op2;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cd <= 0; pend <= 1'b0; m_cnt <= '0;
    end else if (flush) begin
      cd <= 0; pend <= 1'b0;
    end else if (cd > 0) begin
      cd <= cd - 1;
      if (cd == 1) pend <= 1'b1;
    end else if (pend) begin
      if (resp_ready) begin pend <= 1'b0; m_cnt <= m_cnt + 1'b1; end
    end else if (req_valid) begin
      t_op2 = `F_ALU_OP_ADD;
      t_a2 = '0;
      case (req_cmd)
        4'd0: t_op1 = `F_ALU_OP_ADD;  4'd1: t_op1 = `F_ALU_OP_SUB;
        4'd2: t_op1 = `F_ALU_OP_MUL;  4'd3: t_op1 = `F_ALU_OP_MIN;
        4'd4: t_op1 = `F_ALU_OP_MAX;  4'd5: t_op1 = `F_ALU_OP_EQ;
        4'd6: t_op1 = `F_ALU_OP_LT;   4'd7: t_op1 = `F_ALU_OP_LE;
        default: t_op1 = `F_ALU_OP_MUL;
      endcase
      t_prod = fpu_ref(req_rs1, req_rs2, `F_ALU_OP_MUL);
      case (req_cmd)
        4'd8:  begin t_a2 = t_prod;                  t_op2 = `F_ALU_OP_ADD; end // MADD
        4'd9:  begin t_a2 = t_prod;                  t_op2 = `F_ALU_OP_SUB; end // MSUB
        4'd10: begin t_a2 = t_prod ^ 32'h8000_0000;  t_op2 = `F_ALU_OP_ADD; end // NMSUB
        4'd11: begin t_a2 = t_prod ^ 32'h8000_0000;  t_op2 = `F_ALU_OP_SUB; end // NMADD
        default: ;
      endcase
      m_fused <= (req_cmd >= 4'd8 && req_cmd <= 4'd11);
      m_ill   <= (req_cmd >= 4'd12);
      m_a <= req_rs1; m_b <= req_rs2; m_a2 <= t_a2; m_b2 <= req_rs3;
      m_op1 <= t_op1; m_op2 <= t_op2; m_rd <= req_rd;
      if (req_cmd >= 4'd12)     m_res <= '0;
      else if (req_cmd >= 4'd8) m_res <= fpu_ref(t_a2, req_rs3, t_op2);
      else                      m_res <= fpu_ref(req_rs1, req_rs2, t_op1);
      cd <= (req_cmd >= 4'd8 && req_cmd <= 4'd11) ? 2 : 1;
    end
  end

  always @(negedge clk) begin
    chk("req_ready", {31'd0, req_ready}, {31'd0, (cd == 0 && !pend)});
    chk("busy", {31'd0, busy}, {31'd0, (cd != 0 || pend)});
    chk("resp_valid", {31'd0, resp_valid}, {31'd0, pend});
    chk("op_count", 32'(op_count), 32'(m_cnt));
    if (pend) begin
      chk("resp_data", resp_data, m_res);
      chk("resp_rd", {27'd0, resp_rd}, {27'd0, m_rd});
      chk("resp_illegal", {31'd0, resp_illegal}, {31'd0, m_ill});
    end
    if (cd != 0) begin
      if (m_fused && cd == 1) begin
        chk("fpu_a_p2", fpu_a, m_a2);
        chk("fpu_b_p2", fpu_b, m_b2);
        chk("fpu_op_p2", 32'(fpu_op), 32'(m_op2));
      end else begin
        chk("fpu_a_p1", fpu_a, m_a);
        chk("fpu_b_p1", fpu_b, m_b);
        if (!m_ill) chk("fpu_op_p1", 32'(fpu_op), 32'(m_op1));
      end
    end
  end

  localparam logic [31:0] F1_5 = 32'h3FC0_0000, F2_0 = 32'h4000_0000, F0_5 = 32'h3F00_0000;
  logic [31:0] optab [10] = '{32'h3FC00000, 32'h40000000, 32'h3F000000, 32'hC0400000,
                              32'h41200000, 32'hBF800000, 32'h00000000, 32'h42C80000,
                              32'h3E800000, 32'hC1A00000};

  task automatic wait_idle();
    int n = 0;
    while (!req_ready && n < 50) begin @(posedge clk); #1; n++; end
    if (!req_ready) chk("idle_timeout", 32'd0, 32'd1);
  endtask

  task automatic issue(input logic [3:0] c, input logic [31:0] a, b, d, input logic [4:0] rd);
    wait_idle();
    req_valid = 1'b1; req_cmd = c; req_rs1 = a; req_rs2 = b; req_rs3 = d; req_rd = rd;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Checks the response a fixed number of edges after the accepting edge; resp_ready is high.
  task automatic run_dir(input string n, input logic [3:0] c, input logic [31:0] a, b, d,
                         input int lat, input logic [31:0] exp);
    issue(c, a, b, d, 5'd3);
    repeat (lat - 1) @(posedge clk);
    #1;
    chk({n, "_valid"}, {31'd0, resp_valid}, 32'd1);
    chk(n, resp_data, exp);
    @(posedge clk); #1;
  endtask

  logic [CNT_W-1:0] c0;

  initial begin
    #3;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_rd", {27'd0, resp_rd}, 32'd0);
    chk("rst_op_count", 32'(op_count), 32'd0);
    chk("rst_fpu_a", fpu_a, 32'd0);
    chk("rst_fpu_b", fpu_b, 32'd0);
    chk("rst_fpu_op", 32'(fpu_op), 32'(`F_ALU_OP_ADD));
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b1;

    // ADD with latency and completion count pinned by hand.
    issue(4'd0, F1_5, F2_0, 32'd0, 5'd5);
    #1 chk("add_early_valid", {31'd0, resp_valid}, 32'd0);
    @(posedge clk); #1;
    chk("add_valid", {31'd0, resp_valid}, 32'd1);
    chk("add_data", resp_data, 32'h4060_0000);
    chk("add_rd", {27'd0, resp_rd}, 32'd5);
    @(posedge clk); #1;
    chk("add_count", 32'(op_count), 32'd1);

    run_dir("madd", 4'd8, F1_5, F2_0, F0_5, 3, 32'h4060_0000);
    run_dir("msub", 4'd9, F1_5, F2_0, F0_5, 3, 32'h4020_0000);
    run_dir("nmadd", 4'd11, F1_5, F2_0, F0_5, 3, 32'hC060_0000);
    run_dir("nmsub", 4'd10, F1_5, F2_0, F0_5, 3, 32'hC020_0000);
    run_dir("lt", 4'd6, F1_5, F2_0, 32'd0, 2, 32'h0000_0001);

    // Back-pressure: response held stable, no count until the handshake.
    resp_ready = 1'b0;
    c0 = op_count;
    issue(4'd6, F1_5, F2_0, 32'd0, 5'd9);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, resp_valid}, 32'd1);
      chk("bp_data", resp_data, 32'd1);
      chk("bp_req_ready", {31'd0, req_ready}, 32'd0);
      chk("bp_count", 32'(op_count), 32'(c0));
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_count_after", 32'(op_count), 32'(c0 + 1'b1));
    chk("bp_valid_after", {31'd0, resp_valid}, 32'd0);

    // Illegal command, then a legal one must clear the flag.
    issue(4'd13, F1_5, F2_0, 32'd0, 5'd1);
    @(posedge clk); #1;
    chk("ill_flag", {31'd0, resp_illegal}, 32'd1);
    chk("ill_data", resp_data, 32'd0);
    @(posedge clk); #1;
    run_dir("post_ill", 4'd2, F1_5, F2_0, 32'd0, 2, 32'h4040_0000);
    chk("post_ill_flag", {31'd0, resp_illegal}, 32'd0);

    // Flush during PASS2 of NMADD.
    c0 = op_count;
    issue(4'd11, F1_5, F2_0, F0_5, 5'd2);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      chk("flush_valid", {31'd0, resp_valid}, 32'd0);
      chk("flush_count", 32'(op_count), 32'(c0));
      @(posedge clk); #1;
    end
    // flush beats req_valid in IDLE
    req_valid = 1'b1; flush = 1'b1; req_cmd = 4'd0;
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0;
    chk("flush_noaccept", {31'd0, busy}, 32'd0);

    // Asynchronous reset in the middle of PASS1.
    issue(4'd0, F1_5, F2_0, 32'd0, 5'd7);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_count", 32'(op_count), 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Counter wrap with CNT_W=4.
    for (int i = 0; i < 16; i++) begin
      issue(4'd0, optab[i % 10], F2_0, 32'd0, 5'(i));
      @(posedge clk); #1;
      @(posedge clk); #1;
      if (i == 14) chk("cnt_15", 32'(op_count), 32'd15);
    end
    chk("cnt_wrap", 32'(op_count), 32'd0);

    // Randomized traffic; the per-cycle compare does the checking.
    for (int i = 0; i < 600; i++) begin
      req_valid  = ($urandom_range(0, 1) == 1);
      req_cmd    = 4'($urandom_range(0, 15));
      req_rs1    = optab[$urandom_range(0, 9)];
      req_rs2    = optab[$urandom_range(0, 9)];
      req_rs3    = optab[$urandom_range(0, 9)];
      req_rd     = 5'($urandom_range(0, 31));
      resp_ready = ($urandom_range(0, 9) < 6);
      flush      = ($urandom_range(0, 19) == 0);
      @(posedge clk); #1;
    end
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fpu_seq_ctrl.md
Name: fpu_seq_ctrl

Overview:
- Sequencing controller in front of the combinational single-cycle FPU datapath (`fpu`).
- Accepts FP commands over a valid/ready handshake, registers the operands, and drives the FPU's inputA/inputB/FPU_OP from registers.
- Captures the FPU result into a response register.
- Also executes the R4-type fused ops (FMADD/FMSUB/FNMSUB/FNMADD) as two sequential passes through the one shared FPU: multiply, then add/sub. Result is rounded twice, not IEEE-fused.

Parameters:
- CNT_W, 32, width of the completed-operation counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  command valid
- req_ready  output  1  controller can accept a command (high only in IDLE)
- req_cmd  input  4  command code: 0 ADD, 1 SUB, 2 MUL, 3 MIN, 4 MAX, 5 EQ, 6 LT, 7 LE, 8 MADD, 9 MSUB, 10 NMSUB, 11 NMADD, 12-15 illegal
- req_rs1  input  `XLEN  operand 1
- req_rs2  input  `XLEN  operand 2
- req_rs3  input  `XLEN  operand 3 (fused ops only)
- req_rd  input  5  destination tag, returned with response
- resp_valid  output  1  response valid
- resp_ready  input  1  consumer accepts response
- resp_data  output  `XLEN  result
- resp_rd  output  5  destination tag
- resp_illegal  output  1  command code was 12-15
- flush  input  1  synchronous abort
- busy  output  1  state != IDLE
- op_count  output  CNT_W  number of completed responses (handshaken)
- fpu_a  output  `XLEN  to FPU inputA
- fpu_b  output  `XLEN  to FPU inputB
- fpu_op  output  `ALUOPS_SIZE  to FPU_OP, using the `F_ALU_OP_* encodings
- fpu_result  input  `XLEN  from FPU result

Behaviour:
- Reset (rst_n low, async):
  - state=IDLE; all registers cleared.
  - resp_valid=0, resp_data=0, resp_rd=0, resp_illegal=0, op_count=0.
  - fpu_a=0, fpu_b=0, fpu_op=`F_ALU_OP_ADD.
  - req_ready=1 once in IDLE.
- States: IDLE, PASS1, PASS2, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && !flush: latch cmd, rs1, rs2, rs3, rd; go to PASS1.
- PASS1:
  - fpu_a=rs1_q, fpu_b=rs2_q.
  - fpu_op: cmds 0-7 map to ADD/SUB/MUL/MIN/MAX/EQ/LT/LE; cmds 8-11 use MUL.
  - At the edge:
    - cmd 0-7: resp_data<=fpu_result, go to RESP.
    - cmd 8-11: tmp_q<=fpu_result, go to PASS2.
    - cmd 12-15: resp_data<=0, resp_illegal<=1, go to RESP.
- PASS2:
  - fpu_a = tmp_q with bit31 inverted for NMSUB/NMADD, unchanged for MADD/MSUB.
  - fpu_b = rs3_q.
  - fpu_op = ADD for MADD/NMSUB; SUB for MSUB/NMADD.
  - At the edge: resp_data<=fpu_result, go to RESP.
- RESP:
  - resp_valid=1; resp_data, resp_rd, resp_illegal are held stable until the handshake.
  - On resp_ready: op_count increments (wraps at 2^CNT_W); go to IDLE; resp_illegal cleared.
- Latency, counted in edges from the accepting edge:
  - single-pass and illegal: resp_valid high after the 2nd edge.
  - fused: resp_valid high after the 3rd edge.
  - No overlap: the next command is accepted at the earliest the cycle after the response handshake.
- FPU inputs outside PASS1/PASS2 hold their last values; they are don't-care but must not be X after reset.
- flush:
  - In any state, at the edge: go to IDLE, drop the pending response, resp_valid=0, op_count unchanged.
  - flush beats a simultaneous req_valid (no accept) and a simultaneous resp_ready (no count).
- Reset mid-operation: immediate return to the reset values; the in-flight command is lost.
- resp_valid, resp_data, resp_rd and resp_illegal are registered outputs. req_ready and busy are decoded from state only.

Test Plan:
- ADD: rs1=0x3FC00000 (1.5), rs2=0x40000000 (2.0), rd=5, resp_ready=1 → resp_valid on 2nd edge after accept; resp_data=0x40600000, resp_rd=5, op_count=1.
- MADD: rs1=1.5, rs2=2.0, rs3=0x3F000000 (0.5) → resp_data=0x40600000 on 3rd edge. MSUB with the same operands → 0x40200000. NMADD → 0xC0600000. NMSUB → 0xC0200000.
- LT: rs1=1.5, rs2=2.0 → resp_data=0x00000001. Same check with resp_ready held low 5 cycles → resp_valid/resp_data stable and req_ready=0 throughout; op_count increments only on the handshake.
- Illegal cmd=13 → resp_illegal=1, resp_data=0 after 2 edges. The next legal command returns resp_illegal=0.
- flush asserted during PASS2 of an NMADD → IDLE next cycle, no resp_valid, op_count unchanged. flush with req_valid in IDLE → not accepted.
- rst_n pulsed low mid-PASS1 → resp_valid=0, op_count=0, busy=0 immediately. Set op_count near wrap (CNT_W=4, 16 completions) → op_count wraps to 0.
